// File: rtl/bus_operand_sequencer.sv
// Byte-bus front/back end for a multi-cycle arithmetic core: loads operands, pulses the core, returns results.
// Optional CORE_TIMEOUT_EN adds a WAIT watchdog with a sticky err_timeout output.
//
// state   | meaning
// S_LOAD  | accepting operand beats from the input bus
// S_CLR   | one-cycle core_rst pulse before launch
// S_START | one-cycle core_start pulse
// S_WAIT  | waiting for core_done
// S_SEND  | presenting result beats on the output bus
// S_ABORT | watchdog expired: core_rst pulse, then back to S_LOAD (CORE_TIMEOUT_EN only)
module bus_operand_sequencer #(
    parameter int BUS_W       = 8,
    parameter int OP_W        = 16,
    parameter int NUM_OPS     = 2,
    parameter int NUM_RES     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [BUS_W-1:0]        in_data,
    output logic                    in_ready,
    output logic [NUM_OPS*OP_W-1:0] op_bus,
    output logic                    core_rst,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic [NUM_RES*OP_W-1:0] res_bus,
    output logic                    out_valid,
    output logic [BUS_W-1:0]        out_data,
    input  logic                    out_ready,
    output logic                    busy
`ifdef CORE_TIMEOUT_EN
    ,
    output logic                    err_timeout
`endif
);

    localparam int BPO   = OP_W / BUS_W;
    localparam int NIN   = NUM_OPS * BPO;
    localparam int NOUT  = NUM_RES * BPO;
    localparam int NMAX  = (NIN > NOUT) ? NIN : NOUT;
    localparam int CNT_W = (NMAX > 1) ? $clog2(NMAX) : 1;

    if ((OP_W % BUS_W) != 0 || NUM_OPS < 1 || NUM_RES < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("bus_operand_sequencer: illegal parameter combination");
    end

    // Bit position of beat k: operand k/BPO, most significant byte first.
    function automatic int beat_lsb(input int k);
        return (k / BPO) * OP_W + (BPO - 1 - (k % BPO)) * BUS_W;
    endfunction

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_START,
        S_WAIT,
        S_SEND
`ifdef CORE_TIMEOUT_EN
        ,
        S_ABORT
`endif
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [CNT_W-1:0]          r_in_cnt;
    logic [CNT_W-1:0]          r_out_cnt;
    logic [NUM_OPS*OP_W-1:0]   r_op_bus;
    logic [NUM_RES*OP_W-1:0]   r_res;
    logic [BUS_W-1:0]          w_out_data;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_in_last;
    logic                      w_out_last;
    logic                      w_tmo_exp;

    assign w_in_fire  = in_valid && (r_state == S_LOAD);
    assign w_out_fire = out_ready && (r_state == S_SEND);
    assign w_in_last  = (r_in_cnt == CNT_W'(NIN - 1));
    assign w_out_last = (r_out_cnt == CNT_W'(NOUT - 1));

`ifdef CORE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    assign w_tmo_exp   = (r_tmo_cnt == '0);
    assign err_timeout = r_err;

    // Down-counter loaded on launch; terminal count in WAIT means TIMEOUT_CYC cycles elapsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_START)
                r_tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
            else if (r_state == S_WAIT && !w_tmo_exp)
                r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
            if (r_state == S_WAIT && !core_done && w_tmo_exp)
                r_err <= 1'b1;
            else if (w_in_fire)
                r_err <= 1'b0;
        end
    end
`else
    assign w_tmo_exp = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_LOAD;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && w_in_last) w_next = S_CLR;
            S_CLR:   w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (core_done)
                    w_next = S_SEND;
`ifdef CORE_TIMEOUT_EN
                else if (w_tmo_exp)
                    w_next = S_ABORT;
`endif
            end
            S_SEND:  if (w_out_fire && w_out_last) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_op_bus  <= '0;
            r_res     <= '0;
        end else begin
            if (w_in_fire) begin
                for (int k = 0; k < NIN; k++)
                    if (r_in_cnt == CNT_W'(k))
                        r_op_bus[beat_lsb(k) +: BUS_W] <= in_data;
                r_in_cnt <= w_in_last ? '0 : r_in_cnt + CNT_W'(1);
            end
            if (r_state == S_WAIT && core_done)
                r_res <= res_bus;
            if (w_out_fire)
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_out_data = '0;
        if (r_state == S_SEND)
            for (int k = 0; k < NOUT; k++)
                if (r_out_cnt == CNT_W'(k))
                    w_out_data = r_res[beat_lsb(k) +: BUS_W];
    end

    assign in_ready   = (r_state == S_LOAD);
    assign busy       = (r_state != S_LOAD);
    assign out_valid  = (r_state == S_SEND);
    assign out_data   = w_out_data;
    assign op_bus     = r_op_bus;
    assign core_start = (r_state == S_START);
`ifdef CORE_TIMEOUT_EN
    assign core_rst   = (r_state == S_CLR) || (r_state == S_ABORT);
`else
    assign core_rst   = (r_state == S_CLR);
`endif

endmodule
